// File: rtl/vector_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vector_accumulator_pkg
// Description : Shared defaults and saturation helpers for the vector
//               accumulator datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package vector_accumulator_pkg;

  localparam int DEFAULT_DIN_WIDTH  = 16;
  localparam int DEFAULT_DOUT_WIDTH = 32;
  localparam int DEFAULT_VECTOR_LEN = 64;
  localparam int DEFAULT_ACC_WIDTH  = 16;

  // Outcome of a signed addition once it has been checked for overflow.
  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_POS  = 2'd1,
    SAT_NEG  = 2'd2
  } sat_e;

  // Overflow is classified from sign bits alone, so the check works at any
  // width: two like-signed operands producing an opposite-signed result.
  function automatic sat_e sat_kind(input logic sign_a, input logic sign_b,
                                    input logic sign_r);
    if (!sign_a && !sign_b && sign_r) return SAT_POS;
    if (sign_a && sign_b && !sign_r)  return SAT_NEG;
    return SAT_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vector_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : vector_accumulator_if
// Description : Product stream in / integrated sum stream out of the vector
//               accumulator, with control inputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface vector_accumulator_if
  import vector_accumulator_pkg::*;
#(
  parameter int DIN_WIDTH  = DEFAULT_DIN_WIDTH,
  parameter int DOUT_WIDTH = DEFAULT_DOUT_WIDTH,
  parameter int VECTOR_LEN = DEFAULT_VECTOR_LEN,
  parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH
);
  localparam int CHAN_WIDTH = $clog2(VECTOR_LEN);

  logic [ACC_WIDTH-1:0]         acc_len;
  logic                         sync;
  logic signed [DIN_WIDTH-1:0]  din;
  logic                         din_valid;
  logic signed [DOUT_WIDTH-1:0] dout;
  logic [CHAN_WIDTH-1:0]        dout_chan;
  logic                         dout_valid;
  logic                         ovf;

  modport master (
    output acc_len, sync, din, din_valid,
    input  dout, dout_chan, dout_valid, ovf
  );

  modport slave (
    input  acc_len, sync, din, din_valid,
    output dout, dout_chan, dout_valid, ovf
  );

endinterface
`default_nettype wire

// File: rtl/vector_accumulator_bram_sdp.sv
`default_nettype none
// ============================================================================
// Module      : vector_accumulator_bram_sdp
// Description : Simple dual-port RAM, one write port and one registered
//               read port (latency 1, read-first on address collision).
// Revision    : 1.0 - initial release
// ============================================================================
module vector_accumulator_bram_sdp #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  wire logic                     clk,
  input  wire logic                     wr_en,
  input  wire logic [$clog2(DEPTH)-1:0] wr_addr,
  input  wire logic [WIDTH-1:0]         wr_data,
  input  wire logic                     rd_en,
  input  wire logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic      [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; the accumulator ignores stale data.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/vector_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : vector_accumulator
// Description : Integrates per-channel signed products over acc_len frames
//               and dumps one saturated sum per channel on the last frame.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_accumulator
  import vector_accumulator_pkg::*;
#(
  parameter int DIN_WIDTH  = DEFAULT_DIN_WIDTH,
  parameter int DOUT_WIDTH = DEFAULT_DOUT_WIDTH,
  parameter int VECTOR_LEN = DEFAULT_VECTOR_LEN,
  parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH
) (
  input wire logic            clk,
  input wire logic            rst,
  vector_accumulator_if.slave bus
);

  localparam int CHAN_WIDTH = $clog2(VECTOR_LEN);
  localparam logic signed [DOUT_WIDTH-1:0] SAT_MAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [DOUT_WIDTH-1:0] SAT_MIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

  logic [CHAN_WIDTH-1:0]        chan_cnt;
  logic [ACC_WIDTH-1:0]         frame_cnt;
  logic [ACC_WIDTH-1:0]         acc_len_q;
  logic [ACC_WIDTH-1:0]         acc_len_eff;
  logic                         first_frame;
  logic                         last_frame;
  logic                         accept;

  logic                         s0_valid;
  logic signed [DOUT_WIDTH-1:0] s0_din;
  logic [CHAN_WIDTH-1:0]        s0_chan;
  logic                         s0_first;
  logic                         s0_last;

  logic signed [DOUT_WIDTH-1:0] ram_q;
  logic signed [DOUT_WIDTH-1:0] addend;
  logic signed [DOUT_WIDTH-1:0] raw_sum;
  logic signed [DOUT_WIDTH-1:0] sum;
  sat_e                         kind;
  logic                         ovf_flag;
  logic                         flag_next;

  logic signed [DOUT_WIDTH-1:0] dump_sum;
  logic [CHAN_WIDTH-1:0]        dump_chan;
  logic                         dump_valid;
  logic                         ovf_hold;

  // acc_len of zero behaves as a single-frame pass-through.
  assign acc_len_eff = (bus.acc_len == '0) ? ACC_WIDTH'(1) : bus.acc_len;
  assign first_frame = (frame_cnt == '0);
  assign last_frame  = (frame_cnt == acc_len_q - ACC_WIDTH'(1));
  // A sample coinciding with sync is dropped; counting restarts after it.
  assign accept      = bus.din_valid && !bus.sync;

  // Channel/frame position tracking and integration length capture.
  always_ff @(posedge clk) begin
    if (rst || bus.sync) begin
      chan_cnt  <= '0;
      frame_cnt <= '0;
      acc_len_q <= acc_len_eff;
    end else if (bus.din_valid) begin
      chan_cnt <= chan_cnt + CHAN_WIDTH'(1);
      if (&chan_cnt) frame_cnt <= last_frame ? '0 : frame_cnt + ACC_WIDTH'(1);
    end
  end

  // Stage 0: capture the sample and its frame position alongside the RAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
    end else begin
      s0_valid <= accept;
    end
    if (accept) begin
      s0_din   <= DOUT_WIDTH'(bus.din);
      s0_chan  <= chan_cnt;
      s0_first <= first_frame;
      s0_last  <= last_frame;
    end
  end

  // Channel RAM; the last frame writes zero so the slot starts clean.
  vector_accumulator_bram_sdp #(
    .WIDTH (DOUT_WIDTH),
    .DEPTH (VECTOR_LEN)
  ) u_ram (
    .clk     (clk),
    .wr_en   (s0_valid),
    .wr_addr (s0_chan),
    .wr_data (s0_last ? '0 : sum),
    .rd_en   (accept),
    .rd_addr (chan_cnt),
    .rd_data (ram_q)
  );

  // Stage 1 arithmetic: saturating add, and the sticky-flag update where a
  // new integration (channel 0 of its first frame) restarts the window.
  always_comb begin
    addend    = s0_first ? '0 : ram_q;
    raw_sum   = addend + s0_din;
    kind      = sat_kind(addend[DOUT_WIDTH-1], s0_din[DOUT_WIDTH-1],
                         raw_sum[DOUT_WIDTH-1]);
    sum       = raw_sum;
    if (kind == SAT_POS) sum = SAT_MAX;
    if (kind == SAT_NEG) sum = SAT_MIN;
    flag_next = ((s0_chan == '0 && s0_first) ? 1'b0 : ovf_flag) | (kind != SAT_NONE);
  end

  // Stage 1 registers: dump on the last frame, publish ovf at channel 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      dump_sum   <= '0;
      dump_chan  <= '0;
      dump_valid <= 1'b0;
      ovf_hold   <= 1'b0;
      ovf_flag   <= 1'b0;
    end else begin
      dump_valid <= s0_valid && s0_last;
      if (s0_valid) begin
        ovf_flag <= flag_next;
        if (s0_last) begin
          dump_sum  <= sum;
          dump_chan <= s0_chan;
          if (s0_chan == '0) ovf_hold <= flag_next;
        end
      end
    end
  end

  assign bus.dout       = dump_sum;
  assign bus.dout_chan  = dump_chan;
  assign bus.dout_valid = dump_valid;
  assign bus.ovf        = ovf_hold;

endmodule
`default_nettype wire

// File: tb/tb_vector_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_accumulator
// Description : Self-checking bench with a behavioural per-channel model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_accumulator;

  localparam int DIN_W  = 16;
  localparam int DOUT_W = 17;
  localparam int VL     = 4;
  localparam int AW     = 8;
  localparam longint SMAX = (64'sd1 <<< (DOUT_W - 1)) - 1;
  localparam longint SMIN = -SMAX - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vector_accumulator_if #(.DIN_WIDTH(DIN_W), .DOUT_WIDTH(DOUT_W),
                          .VECTOR_LEN(VL), .ACC_WIDTH(AW)) bus ();

  vector_accumulator #(.DIN_WIDTH(DIN_W), .DOUT_WIDTH(DOUT_W),
                       .VECTOR_LEN(VL), .ACC_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Behavioural model state
  longint m_sum [VL];
  int     m_chan, m_frame, m_len;
  bit     m_flag;
  bit     p_valid, p_last, p_upd, p_ovf;
  longint p_sum;
  int     p_chan;
  bit     e_valid, e_ovf;
  longint e_dout;
  int     e_chan;

  // Published expectations for the cycle after each edge
  bit     x_valid, x_ovf;
  longint x_dout;
  int     x_chan;
  bit     check_en = 1'b0;
  int     lit_sel  = 0;

  int vectors = 0;
  int errors  = 0;

  function automatic void model_step(input bit r, input bit s, input int al,
                                     input int d, input bit v);
    bit first, last, sat;
    longint acc;
    if (r) begin
      e_valid = 0; e_dout = 0; e_chan = 0; e_ovf = 0;
      p_valid = 0; m_chan = 0; m_frame = 0; m_flag = 0;
      m_len = (al == 0) ? 1 : al;
      return;
    end
    e_valid = p_valid && p_last;
    if (p_valid && p_last) begin
      e_dout = p_sum;
      e_chan = p_chan;
      if (p_upd) e_ovf = p_ovf;
    end
    if (s) begin
      m_chan = 0; m_frame = 0; m_len = (al == 0) ? 1 : al;
      p_valid = 0;
    end else if (v) begin
      first = (m_frame == 0);
      last  = (m_frame == m_len - 1);
      acc   = first ? longint'(d) : m_sum[m_chan] + longint'(d);
      sat   = 0;
      if (acc > SMAX) begin acc = SMAX; sat = 1; end
      if (acc < SMIN) begin acc = SMIN; sat = 1; end
      if (m_chan == 0 && first) m_flag = 0;
      if (sat) m_flag = 1;
      m_sum[m_chan] = last ? 0 : acc;
      p_valid = 1; p_last = last; p_sum = acc; p_chan = m_chan;
      p_upd = (m_chan == 0) && last; p_ovf = m_flag;
      m_chan = m_chan + 1;
      if (m_chan == VL) begin
        m_chan = 0;
        m_frame = last ? 0 : m_frame + 1;
      end
    end else begin
      p_valid = 0;
    end
  endfunction

  task automatic tick(input bit r, input bit s, input int al, input int d, input bit v);
    rst           = r;
    bus.sync      = s;
    bus.acc_len   = AW'(al);
    bus.din       = DIN_W'(d);
    bus.din_valid = v;
    model_step(r, s, al, d, v);
    @(posedge clk);
    #1;
    x_valid = e_valid; x_dout = e_dout; x_chan = e_chan; x_ovf = e_ovf;
    check_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
  endtask

  function automatic void check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Hand-computed dumps for the directed phases
  longint lit1_dout [4] = '{4, 8, 12, 16};
  longint lit3_dout [8] = '{65535, 65535, 65535, 65535, 4, 4, 4, 4};
  bit     lit3_ovf  [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
  int     lit_cnt   [4] = '{0, 4, 8, 8};

  int lit_idx  = 0;
  int prev_sel = 0;

  // Single compare process: model every cycle, literal tables during directed phases.
  always @(negedge clk) begin
    if (check_en) begin
      check("dout_valid", longint'(bus.dout_valid), longint'(x_valid));
      check("dout", longint'(bus.dout), x_dout);
      check("dout_chan", longint'(bus.dout_chan), longint'(x_chan));
      check("ovf", longint'(bus.ovf), longint'(x_ovf));
      if (lit_sel != prev_sel) begin
        if (prev_sel != 0) check("lit_dump_count", longint'(lit_idx), longint'(lit_cnt[prev_sel]));
        lit_idx  = 0;
        prev_sel = lit_sel;
      end
      if (bus.dout_valid && lit_sel != 0 && lit_idx < lit_cnt[lit_sel]) begin
        check("lit_chan", longint'(bus.dout_chan), longint'(lit_idx % VL));
        case (lit_sel)
          1: begin
            check("lit_sum_ramp", longint'(bus.dout), lit1_dout[lit_idx]);
            check("lit_ovf_ramp", longint'(bus.ovf), 0);
          end
          2: begin
            check("lit_passthru", longint'(bus.dout), -5);
            check("lit_ovf_pass", longint'(bus.ovf), 0);
          end
          default: begin
            check("lit_sat", longint'(bus.dout), lit3_dout[lit_idx]);
            check("lit_ovf_sat", longint'(bus.ovf), longint'(lit3_ovf[lit_idx]));
          end
        endcase
        lit_idx++;
      end else if (bus.dout_valid && lit_sel != 0) begin
        check("lit_extra_dump", longint'(lit_idx), longint'(lit_cnt[lit_sel] - 1));
      end
    end
  end

  initial begin
    int d, al;
    bit r, s;
    bus.sync = 0; bus.din = '0; bus.din_valid = 0; bus.acc_len = AW'(4);

    // Reset, then ramp din=chan+1 over four frames
    tick(1, 0, 4, 0, 0);
    tick(1, 0, 4, 0, 0);
    lit_sel = 1;
    for (int f = 0; f < 4; f++)
      for (int c = 0; c < VL; c++) tick(0, 0, 4, c + 1, 1);
    idle(3);

    // acc_len=1 pass-through
    lit_sel = 2;
    tick(0, 1, 1, 0, 0);
    for (int i = 0; i < 2 * VL; i++) tick(0, 0, 1, -5, 1);
    idle(3);

    // Saturation, then a clean integration
    lit_sel = 3;
    tick(0, 1, 4, 0, 0);
    for (int i = 0; i < 4 * VL; i++) tick(0, 0, 4, 32767, 1);
    for (int i = 0; i < 4 * VL; i++) tick(0, 0, 4, 1, 1);
    idle(3);
    lit_sel = 0;

    // Sync at channel 2 of frame 1, coincident with a valid sample
    tick(0, 1, 3, 0, 0);
    for (int i = 0; i < VL + 2; i++) tick(0, 0, 3, 100 * (i + 1), 1);
    tick(0, 1, 3, 999, 1);
    for (int i = 0; i < 3 * VL; i++) tick(0, 0, 3, i - 7, 1);
    idle(3);

    // Randomized traffic with gaps, occasional sync/reset and extreme values
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 399) == 0);
      s  = !r && ($urandom_range(0, 149) == 0);
      al = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 3;
      if ($urandom_range(0, 7) == 0) d = $urandom_range(0, 1) ? 32767 : -32768;
      else d = int'($urandom_range(0, 2000)) - 1000;
      tick(r, s, al, d, bit'($urandom_range(0, 1)));
      if (i == 1500) tick(1, 0, 3, 0, 1);
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
